regfile_wb_arb: RTL

Write-back arbiter feeding the two write ports of the out-of-order core's physical register file. Collects results from NFU functional units over valid/ready handshakes, buffers each in a small per-unit FIFO, and each cycle grants up to two results round-robin onto the registered write ports (wr0/wa0/i0, wr1/wa1/i1). Guarantees the register file never sees two writes to the same physical register in one cycle.

---
 rtl/regfile_wb_arb_if.sv | 34 +++
 rtl/regfile_wb_arb.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arb_if.sv
// Write-back bus between NFU result producers and the two register file write ports.
// Debug taps expose the round-robin pointer and per-unit FIFO counts.
interface regfile_wb_arb_if #(
    parameter int NFU = 4,
    parameter int AW  = 12,
    parameter int DW  = 64,
    parameter int PW  = (NFU > 1) ? $clog2(NFU) : 1
);
    // A result moves on a rising edge where fu_valid[n] and fu_ready[n] are both high;
    // fu_ready depends only on FIFO state, never on fu_valid, and valid may not be withdrawn by the producer mid-handshake.
    logic [NFU-1:0]    fu_valid;
    logic [NFU-1:0]    fu_ready;
    logic [NFU*AW-1:0] fu_wa;
    logic [NFU*DW-1:0] fu_data;
    logic              wr0;
    logic              wr1;
    logic [AW-1:0]     wa0;
    logic [AW-1:0]     wa1;
    logic [DW-1:0]     i0;
    logic [DW-1:0]     i1;
    logic              idle;
    logic [PW-1:0]     dbg_rr;
    logic [NFU*2-1:0]  dbg_count;

    modport slave (
        input  fu_valid, fu_wa, fu_data,
        output fu_ready, wr0, wr1, wa0, wa1, i0, i1, idle, dbg_rr, dbg_count
    );

    modport master (
        output fu_valid, fu_wa, fu_data,
        input  fu_ready, wr0, wr1, wa0, wa1, i0, i1, idle, dbg_rr, dbg_count
    );
endinterface

// File: rtl/regfile_wb_arb.sv
// Write-back arbiter: per-unit 2-deep FIFOs, round-robin dual grant onto registered write ports.
// Optional macro REGFILE_WB_ARB_R0_DISCARD_EN drops granted writes to register 0.
module regfile_wb_arb #(
    parameter int NFU = 4,
    parameter int AW  = 12,
    parameter int DW  = 64
) (
    input logic             clk,
    input logic             rst_n,
    regfile_wb_arb_if.slave bus
);
    localparam int PW = (NFU > 1) ? $clog2(NFU) : 1;

    logic [1:0]     cnt_q [NFU];
    logic [1:0]     cnt_d [NFU];
    logic [AW-1:0]  wa_q  [NFU][2];
    logic [AW-1:0]  wa_d  [NFU][2];
    logic [DW-1:0]  dat_q [NFU][2];
    logic [DW-1:0]  dat_d [NFU][2];
    logic [PW-1:0]  rr_q, rr_d;
    logic           wr0_q, wr0_d, wr1_q, wr1_d;
    logic [AW-1:0]  wa0_q, wa0_d, wa1_q, wa1_d;
    logic [DW-1:0]  i0_q, i0_d, i1_q, i1_d;

    logic [NFU-1:0] ready;
    logic [NFU-1:0] push;
    logic [NFU-1:0] pop;
    logic           g0_vld, g1_vld;
    logic [PW-1:0]  g0_idx, g1_idx;
    int             g0_off;
    logic           keep0, keep1;
    logic           occupied;
    logic [NFU*2-1:0] cnt_flat;

    function automatic logic [PW-1:0] unit_at(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NFU) s = s - NFU;
        return PW'(s);
    endfunction

    always_comb begin
        for (int n = 0; n < NFU; n++) begin
            ready[n] = rst_n && (cnt_q[n] != 2'd2);
            push[n]  = bus.fu_valid[n] && ready[n];
        end
    end

    // Port 1 continues the scan after port 0 and skips heads that would collide on address.
    always_comb begin
        g0_vld = 1'b0;
        g0_idx = '0;
        g0_off = 0;
        g1_vld = 1'b0;
        g1_idx = '0;
        for (int k = 0; k < NFU; k++) begin
            if (!g0_vld && (cnt_q[unit_at(rr_q, k)] != 2'd0)) begin
                g0_vld = 1'b1;
                g0_idx = unit_at(rr_q, k);
                g0_off = k;
            end
        end
        for (int k = 1; k < NFU; k++) begin
            if (g0_vld && !g1_vld && (k > g0_off)
                && (cnt_q[unit_at(rr_q, k)] != 2'd0)
                && (wa_q[unit_at(rr_q, k)][0] != wa_q[g0_idx][0])) begin
                g1_vld = 1'b1;
                g1_idx = unit_at(rr_q, k);
            end
        end
    end

    always_comb begin
        pop = '0;
        if (g0_vld) pop[g0_idx] = 1'b1;
        if (g1_vld) pop[g1_idx] = 1'b1;
    end

    always_comb begin
        if (g1_vld) begin
            rr_d = unit_at(g1_idx, 1);
        end else if (g0_vld) begin
            rr_d = unit_at(g0_idx, 1);
        end else begin
            rr_d = rr_q;
        end
    end

    always_comb begin
        for (int n = 0; n < NFU; n++) begin
            cnt_d[n]    = cnt_q[n];
            wa_d[n][0]  = wa_q[n][0];
            wa_d[n][1]  = wa_q[n][1];
            dat_d[n][0] = dat_q[n][0];
            dat_d[n][1] = dat_q[n][1];
            if (pop[n]) begin
                wa_d[n][0]  = wa_q[n][1];
                dat_d[n][0] = dat_q[n][1];
            end
            // A push lands in the slot that will be the tail once this edge's pop has shifted.
            if (push[n]) begin
                if ((cnt_q[n] == 2'd0) || ((cnt_q[n] == 2'd1) && pop[n])) begin
                    wa_d[n][0]  = bus.fu_wa[n*AW +: AW];
                    dat_d[n][0] = bus.fu_data[n*DW +: DW];
                end else begin
                    wa_d[n][1]  = bus.fu_wa[n*AW +: AW];
                    dat_d[n][1] = bus.fu_data[n*DW +: DW];
                end
            end
            case ({push[n], pop[n]})
                2'b10:   cnt_d[n] = cnt_q[n] + 2'd1;
                2'b01:   cnt_d[n] = cnt_q[n] - 2'd1;
                default: cnt_d[n] = cnt_q[n];
            endcase
        end
    end

    always_comb begin
`ifdef REGFILE_WB_ARB_R0_DISCARD_EN
        keep0 = g0_vld && (wa_q[g0_idx][0] != '0);
        keep1 = g1_vld && (wa_q[g1_idx][0] != '0);
`else
        keep0 = g0_vld;
        keep1 = g1_vld;
`endif
        wr0_d = keep0;
        wr1_d = keep1;
        wa0_d = wa0_q;
        i0_d  = i0_q;
        wa1_d = wa1_q;
        i1_d  = i1_q;
        if (keep0) begin
            wa0_d = wa_q[g0_idx][0];
            i0_d  = dat_q[g0_idx][0];
        end
        if (keep1) begin
            wa1_d = wa_q[g1_idx][0];
            i1_d  = dat_q[g1_idx][0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < NFU; n++) begin
                cnt_q[n] <= '0;
            end
            rr_q  <= '0;
            wr0_q <= 1'b0;
            wr1_q <= 1'b0;
            wa0_q <= '0;
            wa1_q <= '0;
            i0_q  <= '0;
            i1_q  <= '0;
        end else begin
            for (int n = 0; n < NFU; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
            rr_q  <= rr_d;
            wr0_q <= wr0_d;
            wr1_q <= wr1_d;
            wa0_q <= wa0_d;
            wa1_q <= wa1_d;
            i0_q  <= i0_d;
            i1_q  <= i1_d;
        end
    end

    // Entry storage needs no reset: the counts alone decide which slots are live.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NFU; n++) begin
            for (int s = 0; s < 2; s++) begin
                wa_q[n][s]  <= wa_d[n][s];
                dat_q[n][s] <= dat_d[n][s];
            end
        end
    end

    always_comb begin
        occupied = 1'b0;
        cnt_flat = '0;
        for (int n = 0; n < NFU; n++) begin
            occupied = occupied | (cnt_q[n] != 2'd0);
            cnt_flat[n*2 +: 2] = cnt_q[n];
        end
    end

    assign bus.fu_ready  = ready;
    assign bus.wr0       = wr0_q;
    assign bus.wr1       = wr1_q;
    assign bus.wa0       = wa0_q;
    assign bus.wa1       = wa1_q;
    assign bus.i0        = i0_q;
    assign bus.i1        = i1_q;
    assign bus.idle      = !rst_n || (!occupied && !wr0_q && !wr1_q);
    assign bus.dbg_rr    = rr_q;
    assign bus.dbg_count = cnt_flat;
endmodule
